// File: rtl/stream_multiplexer_rr.sv
// stream_multiplexer_rr: registered N:1 stream mux with fixed-select or round-robin arbitration.
module stream_multiplexer_rr #(
   parameter int NrOfInputs = 4,
   parameter int NrOfBits   = 8,
   parameter int SelBits    = 2
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic                           enable_i,
   input  logic                           mode_i,
   input  logic [SelBits-1:0]             sel_i,
   input  logic [NrOfInputs*NrOfBits-1:0] mux_in_i,
   input  logic [NrOfInputs-1:0]          in_valid_i,
   output logic [NrOfInputs-1:0]          in_ready_o,
   output logic [NrOfBits-1:0]            mux_out_o,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [SelBits-1:0]             out_channel_o
);
   localparam int NSel = 1 << SelBits;
   logic [NrOfBits-1:0] ch [NrOfInputs];
   logic [NSel-1:0]     valid_ext;
   logic [SelBits-1:0]  gnt, idx, last_q, last_d, chan_q, chan_d;
   logic [NrOfBits-1:0] data_q, data_d;
   logic                gnt_ok, accept, valid_q, valid_d;
   for (genvar i = 0; i < NrOfInputs; i++) begin : g_ch
      assign ch[i] = mux_in_i[i*NrOfBits +: NrOfBits];
   end
   // zero-padded so out-of-range select indices read as not valid
   assign valid_ext = NSel'(in_valid_i);
   always_comb begin
      gnt    = sel_i;
      gnt_ok = valid_ext[sel_i];
      idx    = '0;
      if (mode_i) begin
         gnt    = '0;
         gnt_ok = 1'b0;
         // descending search so the nearest channel after last_q wins
         for (int k = NrOfInputs; k >= 1; k--) begin
            idx = SelBits'((int'(last_q) + k) % NrOfInputs);
            if (valid_ext[idx]) begin
               gnt    = idx;
               gnt_ok = 1'b1;
            end
         end
      end
   end
   assign accept     = enable_i & (~valid_q | out_ready_i) & gnt_ok & ~reset_i;
   assign in_ready_o = NrOfInputs'(accept) << gnt;
   always_comb begin
      data_d  = accept ? ch[gnt] : data_q;
      chan_d  = accept ? gnt : chan_q;
      valid_d = accept | (valid_q & ~out_ready_i);
      last_d  = (accept & mode_i) ? gnt : last_q;
   end
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         data_q  <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= SelBits'(NrOfInputs - 1);
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end
   assign mux_out_o     = data_q;
   assign out_channel_o = chan_q;
   assign out_valid_o   = valid_q;
endmodule

// File: tb/tb_stream_multiplexer_rr.sv
// tb_stream_multiplexer_rr: directed vector table on a 4-input instance plus a 3-input corner sequence.
module tb_stream_multiplexer_rr;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, mode, ordy, ov;
   logic [1:0]  sel, och;
   logic [31:0] din;
   logic [3:0]  ival, irdy;
   logic [7:0]  mo;

   logic        rst3, en3, mode3, ordy3, ov3;
   logic [1:0]  sel3, och3;
   logic [23:0] din3;
   logic [2:0]  ival3, irdy3;
   logic [7:0]  mo3;

   stream_multiplexer_rr #(.NrOfInputs(4), .NrOfBits(8), .SelBits(2)) u4 (
      .clock_i(clk), .reset_i(rst), .enable_i(en), .mode_i(mode), .sel_i(sel),
      .mux_in_i(din), .in_valid_i(ival), .in_ready_o(irdy), .mux_out_o(mo),
      .out_valid_o(ov), .out_ready_i(ordy), .out_channel_o(och));

   stream_multiplexer_rr #(.NrOfInputs(3), .NrOfBits(8), .SelBits(2)) u3 (
      .clock_i(clk), .reset_i(rst3), .enable_i(en3), .mode_i(mode3), .sel_i(sel3),
      .mux_in_i(din3), .in_valid_i(ival3), .in_ready_o(irdy3), .mux_out_o(mo3),
      .out_valid_o(ov3), .out_ready_i(ordy3), .out_channel_o(och3));

   typedef struct {
      logic        rst, en, mode;
      logic [1:0]  sel;
      logic [3:0]  valid;
      logic        ready;
      logic [31:0] data;
      logic [3:0]  rdy;
      logic        ov;
      logic [7:0]  mo;
      logic [1:0]  ch;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t v[$];

   function automatic vec_t mk(logic r, logic e, logic m, logic [1:0] s, logic [3:0] va, logic rd,
                               logic [31:0] d, logic [3:0] xr, logic xo, logic [7:0] xm, logic [1:0] xc);
      vec_t t;
      t.rst = r; t.en = e; t.mode = m; t.sel = s; t.valid = va; t.ready = rd; t.data = d;
      t.rdy = xr; t.ov = xo; t.mo = xm; t.ch = xc;
      return t;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step3(string tag, logic r, logic e, logic m, logic [1:0] s, logic [2:0] va, logic rd,
                        logic [2:0] xr, logic xo, logic [7:0] xm, logic [1:0] xc);
      rst3 = r; en3 = e; mode3 = m; sel3 = s; ival3 = va; ordy3 = rd;
      #3;
      chk({tag, " in_ready"}, 32'(irdy3), 32'(xr));
      @(posedge clk);
      #1;
      chk({tag, " out_valid"}, 32'(ov3), 32'(xo));
      chk({tag, " mux_out"}, 32'(mo3), 32'(xm));
      chk({tag, " out_channel"}, 32'(och3), 32'(xc));
   endtask

   localparam logic [31:0] D  = 32'h13121110;
   localparam logic [31:0] DA = 32'h13A51110;

   initial begin
      rst = 1; en = 0; mode = 0; sel = 0; ival = 0; ordy = 0; din = D;
      rst3 = 1; en3 = 0; mode3 = 0; sel3 = 0; ival3 = 0; ordy3 = 0; din3 = 24'h222120;

      v.push_back(mk(1,1,1,0,4'hF,1,D, 4'h0,0,8'h00,0));
      v.push_back(mk(1,1,1,0,4'hF,1,D, 4'h0,0,8'h00,0));
      repeat (3) v.push_back(mk(0,1,0,2,4'h4,1,DA, 4'h4,1,8'hA5,2));
      repeat (2) begin
         v.push_back(mk(0,1,1,0,4'hF,1,D, 4'h1,1,8'h10,0));
         v.push_back(mk(0,1,1,0,4'hF,1,D, 4'h2,1,8'h11,1));
         v.push_back(mk(0,1,1,0,4'hF,1,D, 4'h4,1,8'h12,2));
         v.push_back(mk(0,1,1,0,4'hF,1,D, 4'h8,1,8'h13,3));
      end
      v.push_back(mk(0,1,1,0,4'hA,1,D, 4'h2,1,8'h11,1));
      v.push_back(mk(0,1,1,0,4'hA,1,D, 4'h8,1,8'h13,3));
      v.push_back(mk(0,1,1,0,4'hA,1,D, 4'h2,1,8'h11,1));
      repeat (3) v.push_back(mk(0,1,1,0,4'hF,0,D, 4'h0,1,8'h11,1));
      v.push_back(mk(0,1,1,0,4'hF,1,D, 4'h4,1,8'h12,2));
      repeat (2) v.push_back(mk(0,0,1,0,4'hF,1,D, 4'h0,0,8'h12,2));
      v.push_back(mk(0,1,1,0,4'hF,1,D, 4'h8,1,8'h13,3));
      v.push_back(mk(0,1,1,0,4'hF,0,D, 4'h0,1,8'h13,3));
      v.push_back(mk(1,1,1,0,4'hF,0,D, 4'h0,0,8'h00,0));
      v.push_back(mk(0,1,1,0,4'hF,1,D, 4'h1,1,8'h10,0));

      @(posedge clk);
      #1;
      foreach (v[i]) begin
         rst = v[i].rst; en = v[i].en; mode = v[i].mode; sel = v[i].sel;
         ival = v[i].valid; ordy = v[i].ready; din = v[i].data;
         #3;
         chk($sformatf("v%0d in_ready", i), 32'(irdy), 32'(v[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", i), 32'(ov), 32'(v[i].ov));
         chk($sformatf("v%0d mux_out", i), 32'(mo), 32'(v[i].mo));
         chk($sformatf("v%0d out_channel", i), 32'(och), 32'(v[i].ch));
      end
      rst = 0; en = 0; ival = 0;

      step3("n3 reset",   1,1,1,0,3'b111,1, 3'b000,0,8'h00,0);
      step3("n3 sel1",    0,1,0,1,3'b111,1, 3'b010,1,8'h21,1);
      step3("n3 sel3",    0,1,0,3,3'b111,1, 3'b000,0,8'h21,1);
      step3("n3 sel3b",   0,1,0,3,3'b111,1, 3'b000,0,8'h21,1);
      step3("n3 en_low",  0,0,1,0,3'b111,1, 3'b000,0,8'h21,1);
      step3("n3 rr0",     0,1,1,0,3'b111,1, 3'b001,1,8'h20,0);
      step3("n3 rr1",     0,1,1,0,3'b111,1, 3'b010,1,8'h21,1);
      step3("n3 rr2",     0,1,1,0,3'b111,1, 3'b100,1,8'h22,2);
      step3("n3 rrwrap",  0,1,1,0,3'b111,1, 3'b001,1,8'h20,0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
